// File: rtl/leastsquares_ctrl_pkg.sv
// Shared definitions for the SSD accumulator sequencer: accumulator op codes,
// FSM state encoding and the datapath width.
package ls_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] ACC_ADD = 2'd0;
    localparam logic [1:0] ACC_FIN = 2'd1;
    localparam logic [1:0] ACC_CLR = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_CLR_S  = 4'd1,
        ST_CLR_P  = 4'd2,
        ST_WAIT   = 4'd3,
        ST_ACC_P  = 4'd4,
        ST_FIN_S  = 4'd5,
        ST_FIN_P  = 4'd6,
        ST_CAPT   = 4'd7,
        ST_RESULT = 4'd8,
        ST_ABT_S  = 4'd9,
        ST_ABT_P  = 4'd10
    } state_t;

endpackage

// File: rtl/leastsquares_ctrl.sv
// Sequencer for the SSD accumulator: clear, one accumulate per operand pair, finish,
// then hand the captured sum out on a valid/ready result port.
//
// state  | meaning
// IDLE   | waiting for start
// CLR_S  | clear op set up (mode 2)
// CLR_P  | clear strobe
// WAIT   | s_ready high, waiting for a pair or abort
// ACC_P  | accumulate strobe, pair count decremented
// FIN_S  | finish op set up (mode 1)
// FIN_P  | finish strobe
// CAPT   | capture acc_data / acc_done into the result registers
// RESULT | result held until res_ready
// ABT_S  | abort clear op set up
// ABT_P  | abort clear strobe
module leastsquares_ctrl
    import ls_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk_n,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              abort,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_a,
    input  logic [DATA_W-1:0] s_b,
    output logic [DATA_W-1:0] acc_a,
    output logic [DATA_W-1:0] acc_b,
    output logic [1:0]        acc_mode,
    output logic              acc_strobe,
    input  logic              acc_done,
    input  logic [DATA_W-1:0] acc_data,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_err,
    output logic              busy
);

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  acc_a_q, acc_a_d;
    logic [DATA_W-1:0]  acc_b_q, acc_b_d;
    logic [1:0]         acc_mode_q, acc_mode_d;
    logic               acc_strobe_q, acc_strobe_d;
    logic               s_ready_q, s_ready_d;
    logic               res_valid_q, res_valid_d;
    logic [DATA_W-1:0]  res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic               busy_q, busy_d;

    always_ff @(posedge clk_n or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            acc_a_q      <= '0;
            acc_b_q      <= '0;
            acc_mode_q   <= ACC_CLR;
            acc_strobe_q <= 1'b0;
            s_ready_q    <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            acc_a_q      <= acc_a_d;
            acc_b_q      <= acc_b_d;
            acc_mode_q   <= acc_mode_d;
            acc_strobe_q <= acc_strobe_d;
            s_ready_q    <= s_ready_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CLR_S;
                    cnt_d   = len;
                end
            end
            ST_CLR_S: state_d = ST_CLR_P;
            ST_CLR_P: state_d = (cnt_q == '0) ? ST_FIN_S : ST_WAIT;
            ST_WAIT: begin
                if (abort) begin
                    state_d = ST_ABT_S;
                end else if (s_valid) begin
                    state_d = ST_ACC_P;
                end
            end
            ST_ACC_P: begin
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? ST_FIN_S : ST_WAIT;
            end
            ST_FIN_S:  state_d = ST_FIN_P;
            ST_FIN_P:  state_d = ST_CAPT;
            ST_CAPT:   state_d = ST_RESULT;
            ST_RESULT: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABT_S:  state_d = ST_ABT_P;
            ST_ABT_P:  state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so every pin comes straight off a flop.
    always_comb begin
        acc_a_d      = acc_a_q;
        acc_b_d      = acc_b_q;
        acc_mode_d   = acc_mode_q;
        acc_strobe_d = 1'b0;
        s_ready_d    = 1'b0;
        res_valid_d  = 1'b0;
        res_data_d   = res_data_q;
        res_err_d    = res_err_q;
        busy_d       = (state_d != ST_IDLE);
        case (state_d)
            ST_CLR_S, ST_ABT_S: acc_mode_d = ACC_CLR;
            ST_FIN_S:           acc_mode_d = ACC_FIN;
            ST_WAIT: begin
                s_ready_d  = 1'b1;
                acc_mode_d = ACC_ADD;
            end
            ST_CLR_P, ST_ACC_P, ST_FIN_P, ST_ABT_P: acc_strobe_d = 1'b1;
            ST_RESULT: res_valid_d = 1'b1;
            default: ;
        endcase
        if (state_q == ST_WAIT && state_d == ST_ACC_P) begin
            acc_a_d = s_a;
            acc_b_d = s_b;
        end
        if (state_q == ST_CAPT) begin
            res_data_d = acc_data;
            res_err_d  = ~acc_done;
        end
    end

    assign acc_a      = acc_a_q;
    assign acc_b      = acc_b_q;
    assign acc_mode   = acc_mode_q;
    assign acc_strobe = acc_strobe_q;
    assign s_ready    = s_ready_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_err    = res_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_leastsquares_ctrl.sv
// Bench for leastsquares_ctrl: behavioural accumulator, queue-based expectation model
// checked every cycle, plus directed runs with hand-computed results.
module tb_leastsquares_ctrl;
    import ls_pkg::*;

    logic        clk_n = 1'b0;
    logic        rst;
    logic        start, abort, s_valid, res_ready;
    logic [15:0] len;
    logic [31:0] s_a, s_b;
    logic        s_ready;
    logic [31:0] acc_a, acc_b;
    logic [1:0]  acc_mode;
    logic        acc_strobe;
    logic        acc_done = 1'b0;
    logic [31:0] acc_data = 32'hDEAD_BEEF;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_err;
    logic        busy;

    leastsquares_ctrl #(.LEN_W(16)) dut (
        .clk_n(clk_n), .rst(rst), .start(start), .len(len), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .acc_a(acc_a), .acc_b(acc_b), .acc_mode(acc_mode), .acc_strobe(acc_strobe),
        .acc_done(acc_done), .acc_data(acc_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_err(res_err), .busy(busy)
    );

    always #5 clk_n = ~clk_n;

    // Accumulator stand-in; not reset, so its contents go stale across a controller reset.
    logic acc_break = 1'b0;
    always @(posedge clk_n) begin
        if (acc_strobe) begin
            case (acc_mode)
                2'd0: acc_data <= acc_data + (acc_a - acc_b) * (acc_a - acc_b);
                2'd1: acc_done <= !acc_break;
                2'd2: begin acc_data <= '0; acc_done <= 1'b0; end
                default: ;
            endcase
        end
    end

    int n_chk = 0, n_pass = 0, cyc = 0, strobe_cnt = 0;
    logic [1:0]  exp_mode_q[$];
    logic [31:0] exp_a_q[$], exp_b_q[$], exp_res_q[$];
    logic        exp_err_q[$];
    logic        prev_strobe = 1'b0, prev_s_ready = 1'b0, prev_res_valid = 1'b0;
    logic [31:0] pa[0:7], pb[0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    task automatic monitor();
        logic [1:0]  m;
        logic [31:0] ea, eb;
        if (res_ready && prev_res_valid && exp_res_q.size() > 0) begin
            void'(exp_res_q.pop_front());
            void'(exp_err_q.pop_front());
        end
        if (res_valid) begin
            chk("res_expected", 32'(exp_res_q.size() > 0), 1);
            if (exp_res_q.size() > 0) begin
                chk("res_data", res_data, exp_res_q[0]);
                chk("res_err", 32'(res_err), 32'(exp_err_q[0]));
            end
        end
        if (s_valid && prev_s_ready) chk("s_ready_after_hs", 32'(s_ready), 0);
        if (acc_strobe) begin
            strobe_cnt++;
            chk("strobe_gap", 32'(prev_strobe), 0);
            chk("strobe_expected", 32'(exp_mode_q.size() > 0), 1);
            if (exp_mode_q.size() > 0) begin
                m = exp_mode_q.pop_front();
                chk("strobe_mode", 32'(acc_mode), 32'(m));
                if (m == ACC_ADD && exp_a_q.size() > 0) begin
                    ea = exp_a_q.pop_front();
                    eb = exp_b_q.pop_front();
                    chk("acc_a", acc_a, ea);
                    chk("acc_b", acc_b, eb);
                end
            end
        end
        prev_strobe    = acc_strobe;
        prev_s_ready   = s_ready;
        prev_res_valid = res_valid;
    endtask

    task automatic tick();
        @(negedge clk_n);
        cyc++;
        if (rst) begin
            prev_strobe = 1'b0; prev_s_ready = 1'b0; prev_res_valid = 1'b0;
        end else begin
            monitor();
        end
    endtask

    // One run: n pairs from pa/pb, optional abort after k pairs, idle gap between pairs,
    // and res_ready withheld for 'hold' cycles (with a stray start pulse inside the hold).
    task automatic do_run(input int n, input int k_abort, input int gap, input int hold,
                          output logic [31:0] got, output logic got_err,
                          output int lat, output logic [31:0] msum);
        int          npairs, t0, b;
        logic [63:0] ad;
        npairs = (k_abort >= 0) ? k_abort : n;
        msum = '0; got = '0; got_err = 1'b0; lat = 0;
        exp_mode_q.push_back(ACC_CLR);
        for (int i = 0; i < npairs; i++) begin
            exp_mode_q.push_back(ACC_ADD);
            exp_a_q.push_back(pa[i]);
            exp_b_q.push_back(pb[i]);
            ad = (pa[i] > pb[i]) ? 64'(pa[i] - pb[i]) : 64'(pb[i] - pa[i]);
            msum = 32'(64'(msum) + ad * ad);
        end
        if (k_abort >= 0) begin
            exp_mode_q.push_back(ACC_CLR);
        end else begin
            exp_mode_q.push_back(ACC_FIN);
            exp_res_q.push_back(msum);
            exp_err_q.push_back(acc_break);
        end
        start = 1'b1; len = 16'(n); t0 = cyc;
        tick();
        start = 1'b0;
        for (int i = 0; i < npairs; i++) begin
            s_valid = 1'b1; s_a = pa[i]; s_b = pb[i];
            b = 0;
            while (!s_ready && b < 100) begin tick(); b++; end
            if (b >= 100) chk("s_ready_timeout", 32'(s_ready), 1);
            tick();
            s_valid = 1'b0;
            repeat (gap) tick();
        end
        if (k_abort >= 0) begin
            b = 0;
            while (!s_ready && b < 100) begin tick(); b++; end
            if (b >= 100) chk("abort_wait_timeout", 32'(s_ready), 1);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            repeat (3) tick();
            chk("abort_idle", 32'(busy), 0);
            chk("abort_modes_left", 32'(exp_mode_q.size()), 0);
        end else begin
            b = 0;
            while (!res_valid && b < 200) begin tick(); b++; end
            if (b >= 200) chk("res_valid_timeout", 32'(res_valid), 1);
            lat = cyc - t0;
            for (int i = 0; i < hold; i++) begin
                if (i == 3) start = 1'b1;
                tick();
                start = 1'b0;
            end
            if (hold > 0) chk("hold_valid", 32'(res_valid), 1);
            got = res_data; got_err = res_err;
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
            chk("idle_after_run", 32'(busy), 0);
            chk("res_consumed", 32'(exp_res_q.size()), 0);
            chk("modes_left", 32'(exp_mode_q.size()), 0);
        end
    endtask

    logic [31:0] got, msum;
    logic        got_err;
    int          lat, s0, b;

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; res_ready = 1'b0;
        len = '0; s_a = '0; s_b = '0;
        tick(); tick();
        chk("rst_acc_mode", 32'(acc_mode), 2);
        chk("rst_strobe", 32'(acc_strobe), 0);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_acc_a", acc_a, 0);
        rst = 1'b0;
        tick();

        // 1: three pairs -> 4 + 25 + 0
        pa[0] = 5; pb[0] = 3; pa[1] = 2; pb[1] = 7; pa[2] = 10; pb[2] = 10;
        s0 = strobe_cnt;
        do_run(3, -1, 0, 0, got, got_err, lat, msum);
        chk("t1_model_sum", msum, 29);
        chk("t1_res", got, 29);
        chk("t1_err", 32'(got_err), 0);
        chk("t1_strobes", 32'(strobe_cnt - s0), 5);
        chk("t1_latency", 32'(lat), 12);

        // 2: len 0 -> clear then finish
        s0 = strobe_cnt;
        do_run(0, -1, 0, 0, got, got_err, lat, msum);
        chk("t2_res", got, 0);
        chk("t2_latency", 32'(lat), 6);
        chk("t2_strobes", 32'(strobe_cnt - s0), 2);

        // 3: first square wraps to zero
        pa[0] = 32'h0001_0000; pb[0] = 0; pa[1] = 3; pb[1] = 1;
        do_run(2, -1, 0, 0, got, got_err, lat, msum);
        chk("t3_model_sum", msum, 4);
        chk("t3_res", got, 4);

        // 4: abort after two of four pairs, then a clean run
        pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 5; pa[2] = 7; pb[2] = 7; pa[3] = 9; pb[3] = 9;
        s0 = strobe_cnt;
        do_run(4, 2, 0, 0, got, got_err, lat, msum);
        chk("t4_abort_strobes", 32'(strobe_cnt - s0), 4);
        chk("t4_no_result", 32'(res_valid), 0);
        pa[0] = 4; pb[0] = 1;
        do_run(1, -1, 0, 0, got, got_err, lat, msum);
        chk("t4_res", got, 9);

        // 5: result held 10 cycles with a stray start
        pa[0] = 6; pb[0] = 2;
        do_run(1, -1, 0, 10, got, got_err, lat, msum);
        chk("t5_res", got, 16);
        chk("t5_latency", 32'(lat), 8);
        repeat (3) tick();
        chk("t5_start_ignored", 32'(busy), 0);

        // 6: reset while strobing
        exp_mode_q.push_back(ACC_CLR);
        start = 1'b1; len = 16'd3;
        tick();
        start = 1'b0;
        b = 0;
        while (!acc_strobe && b < 20) begin tick(); b++; end
        chk("t6_strobe_seen", 32'(acc_strobe), 1);
        #1 rst = 1'b1;
        #1;
        chk("t6_rst_strobe", 32'(acc_strobe), 0);
        chk("t6_rst_busy", 32'(busy), 0);
        chk("t6_rst_mode", 32'(acc_mode), 2);
        chk("t6_rst_res_data", res_data, 0);
        chk("t6_rst_res_err", 32'(res_err), 0);
        chk("t6_rst_s_ready", 32'(s_ready), 0);
        chk("t6_rst_acc_b", acc_b, 0);
        tick();
        exp_mode_q.delete(); exp_a_q.delete(); exp_b_q.delete();
        exp_res_q.delete(); exp_err_q.delete();
        rst = 1'b0;
        repeat (3) tick();
        chk("t6_no_strobe_after_rst", 32'(acc_strobe), 0);

        // gaps between pairs must not add strobes; stale sum is cleared first
        pa[0] = 3; pb[0] = 0; pa[1] = 1; pb[1] = 1;
        s0 = strobe_cnt;
        do_run(2, -1, 3, 0, got, got_err, lat, msum);
        chk("t6_gap_res", got, 9);
        chk("t6_gap_strobes", 32'(strobe_cnt - s0), 4);

        // accumulator that never reports done -> res_err
        acc_break = 1'b1;
        pa[0] = 2; pb[0] = 2;
        do_run(1, -1, 0, 0, got, got_err, lat, msum);
        chk("t6_err_flag", 32'(got_err), 1);
        chk("t6_err_res", got, 0);
        acc_break = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
